run_readout_ctrl: RTL

Sequencer between the board-level start/startIO controls and the processor core. On a start request it holds the core in reset, releases it, and waits for the core's end flag under a watchdog. It then streams a fixed window of data memory out one byte at a time on a paced strobe, gated by startIO. It sits in `top` between the core, the data-memory second read port, and the byte-output pins (clk_out / ReadDataOut).

---
 rtl/run_readout_ctrl.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/run_readout_ctrl.sv
// -----------------------------------------------------------------------------
// run_readout_ctrl
//
// Sequencer between the board-level start/startIO controls and the processor
// core. A start rising edge holds the core in reset for CORE_RST_CYC cycles and
// then releases it. The block waits for the core's end flag under a watchdog.
// After that it freezes the core again and streams NUM_BYTES bytes of data
// memory, starting at BASE_ADDR, onto byte_out with a paced strobe. startIO
// gates the stream between bytes.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   start        in   run request, acted on at its rising edge
//   startIO      in   level enable for the output stream; low pauses between bytes
//   end_flag     in   core finished (level)
//   mem_rdata    in   data-memory read data, valid one cycle after mem_addr/mem_re
//   core_rst     out  active-high reset to the core (low only in RUN)
//   mem_addr     out  data-memory byte read address (BASE_ADDR+idx, wraps)
//   mem_re       out  read strobe to data memory (high only in FETCH)
//   byte_out     out  current output byte
//   byte_strobe  out  output strobe; byte_out is stable while it is high
//   busy         out  high in every state except IDLE, DONE, ERROR
//   done         out  high in DONE
//   error        out  high in ERROR (watchdog expired)
//   dbg_state    out  current FSM state encoding (state_t below)
//
// Memory read timing: mem_addr/mem_re are registered on entry to FETCH. The
// memory samples them at the end of FETCH and presents mem_rdata during the
// first EMIT cycle. byte_out captures it at the end of that cycle.
//
// Byte slot: one FETCH cycle followed by STROBE_DIV EMIT cycles. The strobe is
// low in FETCH and in EMIT cycle 0, while byte_out changes. It is high for the
// next STROBE_DIV/2 EMIT cycles, then low until the slot ends.
//
// All outputs are registered. Each one is decoded from the next state, or from
// the current slot position, and loaded on the clock edge.
// -----------------------------------------------------------------------------
module run_readout_ctrl #(
  parameter int ADDR_W       = 16,
  parameter int BASE_ADDR    = 0,
  parameter int NUM_BYTES    = 256,
  parameter int CORE_RST_CYC = 4,
  parameter int STROBE_DIV   = 8,
  parameter int WDOG_W       = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              startIO,
  input  logic              end_flag,
  input  logic [7:0]        mem_rdata,
  output logic              core_rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic [7:0]        byte_out,
  output logic              byte_strobe,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  localparam int IDX_W  = $clog2(NUM_BYTES + 1);
  localparam int CLR_W  = (CORE_RST_CYC > 1) ? $clog2(CORE_RST_CYC) : 1;
  localparam int SLOT_W = $clog2(STROBE_DIV);

  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CORE_RST_CYC - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(STROBE_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_HIGH = SLOT_W'(STROBE_DIV / 2);
  localparam logic [IDX_W-1:0]  IDX_END   = IDX_W'(NUM_BYTES);
  // The watchdog counts to all-ones. Leaving RUN from the value one below
  // all-ones makes ERROR the cycle the count would reach all-ones.
  localparam logic [WDOG_W-1:0] WDOG_LAST = ~WDOG_W'(1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_WAIT_IO = 3'd3,
    S_FETCH   = 3'd4,
    S_EMIT    = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_start_q;
  logic                r_start_q2;
  logic [CLR_W-1:0]    r_clr_cnt;
  logic [WDOG_W-1:0]   r_wdog;
  logic [IDX_W-1:0]    r_idx;
  logic [SLOT_W-1:0]   r_slot;

  logic                r_core_rst;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_re;
  logic [7:0]          r_byte_out;
  logic                r_strobe;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  logic                w_start_rise;
  logic                w_run_first;
  logic                w_slot_end;
  logic [IDX_W-1:0]    w_idx_inc;
  logic [IDX_W-1:0]    w_fetch_idx;

  logic                w_core_rst_nxt;
  logic                w_mem_re_nxt;
  logic                w_strobe_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_error_nxt;

  // Start is sampled once and then edge-detected against its previous sample.
  // This costs one clock between the sampling edge and the move to CLEAR.
  assign w_start_rise = r_start_q & ~r_start_q2;

  // The watchdog is zero only in the first RUN cycle. That cycle ignores
  // end_flag, so a flag still high from the previous run is not taken.
  assign w_run_first  = (r_wdog == '0);
  assign w_slot_end   = (r_slot == SLOT_LAST);
  assign w_idx_inc    = r_idx + IDX_W'(1);

  // When FETCH follows EMIT directly, idx advances on the same edge. The
  // address must therefore use the incremented value.
  assign w_fetch_idx  = (r_state == S_EMIT) ? w_idx_inc : r_idx;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_start_rise) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (r_clr_cnt == CLR_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (end_flag && !w_run_first) w_state_nxt = S_WAIT_IO;
        else if (r_wdog == WDOG_LAST) w_state_nxt = S_ERROR;
      end
      S_WAIT_IO: begin
        if (startIO) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        // startIO is checked only at slot end. A drop mid-slot lets the
        // current byte finish.
        if (w_slot_end) begin
          if (w_idx_inc == IDX_END) w_state_nxt = S_DONE;
          else if (startIO)         w_state_nxt = S_FETCH;
          else                      w_state_nxt = S_WAIT_IO;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: values the output registers take on the coming edge
  // ---------------------------------------------------------------------------
  always_comb begin
    w_core_rst_nxt = (w_state_nxt != S_RUN);
    w_mem_re_nxt   = (w_state_nxt == S_FETCH);
    w_busy_nxt     = !(w_state_nxt inside {S_IDLE, S_DONE, S_ERROR});
    w_done_nxt     = (w_state_nxt == S_DONE);
    w_error_nxt    = (w_state_nxt == S_ERROR);
    // Slot positions 0..STROBE_DIV/2-1 drive the strobe during EMIT cycles
    // 1..STROBE_DIV/2. The strobe stays low in cycle 0, while byte_out loads.
    w_strobe_nxt   = (r_state == S_EMIT) && (r_slot < SLOT_HIGH);
  end

  // ---------------------------------------------------------------------------
  // Counters and start sampling
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_q  <= 1'b0;
      r_start_q2 <= 1'b0;
      r_clr_cnt  <= '0;
      r_wdog     <= '0;
      r_idx      <= '0;
      r_slot     <= '0;
    end else begin
      r_start_q  <= start;
      r_start_q2 <= r_start_q;

      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + CLR_W'(1);
      else                    r_clr_cnt <= '0;

      // Clears whenever RUN is left or not occupied: on end_flag, on error,
      // and on every restart.
      if (r_state == S_RUN && w_state_nxt == S_RUN) r_wdog <= r_wdog + WDOG_W'(1);
      else                                          r_wdog <= '0;

      if (w_state_nxt == S_CLEAR)               r_idx <= '0;
      else if (r_state == S_EMIT && w_slot_end) r_idx <= w_idx_inc;

      if (r_state == S_EMIT && w_state_nxt == S_EMIT) r_slot <= r_slot + SLOT_W'(1);
      else                                            r_slot <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_core_rst <= 1'b1;
      r_mem_addr <= '0;
      r_mem_re   <= 1'b0;
      r_byte_out <= '0;
      r_strobe   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_core_rst <= w_core_rst_nxt;
      r_mem_re   <= w_mem_re_nxt;
      r_strobe   <= w_strobe_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;

      // The address is modulo 2^ADDR_W, so wrapping past the top is intended.
      if (w_state_nxt == S_FETCH) r_mem_addr <= BASE + ADDR_W'(w_fetch_idx);

      // Read data is valid in the first EMIT cycle only.
      if (r_state == S_EMIT && r_slot == '0) r_byte_out <= mem_rdata;
    end
  end

  assign core_rst    = r_core_rst;
  assign mem_addr    = r_mem_addr;
  assign mem_re      = r_mem_re;
  assign byte_out    = r_byte_out;
  assign byte_strobe = r_strobe;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign dbg_state   = r_state;

endmodule
